// File: rtl/led_code_sched_pkg.sv
// led_code_sched_pkg: shared types and constants for the LED code scheduler
// Holds the scheduler state enum, the blink-code width, the requester limit
// and a small helper used to size the shared cycle counter.
package led_code_sched_pkg;

    localparam int CODE_W  = 4;
    localparam int MAX_REQ = 8;
    localparam int ID_W    = $clog2(MAX_REQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_code_sched_rr.sv
// rr_arbiter: combinational round-robin pick of the first request after ptr
// Ports:
//   req  - request vector, one bit per requester
//   ptr  - index of the requester served last
//   gnt  - one-hot grant (all zero when nothing requests)
//   idx  - index of the granted requester (0 when nothing requests)
module rr_arbiter
    import led_code_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] idx
);

    logic hit;

    // First pass looks strictly above ptr, second pass wraps to the bottom;
    // together they scan ptr+1 .. ptr in circular order.
    always_comb begin
        gnt = '0;
        idx = '0;
        hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!hit && req[i] && i > int'(ptr)) begin
                hit    = 1'b1;
                gnt[i] = 1'b1;
                idx    = ID_W'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!hit && req[i]) begin
                hit    = 1'b1;
                gnt[i] = 1'b1;
                idx    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/led_code_sched.sv
// led_code_sched: round-robin scheduler sharing one LED flasher among requesters
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   req_valid    - per-requester one-cycle post strobe
//   req_code     - per-requester blink count, nibble i for requester i
//   req_fast     - per-requester fast-blink flag
//   req_done     - one-cycle pulse when requester's code finished or was dropped
//   pending      - requester holds an unserved code
//   fl_mode      - code to flasher, nonzero for exactly one cycle per issue
//   fl_fast      - fast flag to flasher, valid with fl_mode
//   fl_busy      - flasher busy
//   active       - a code is in flight; active_id is its requester
//   err_nostart  - sticky: flasher never went busy after an issue
module led_code_sched
    import led_code_sched_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int START_TMO = 8,
    parameter int GAP_CYC   = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [CODE_W*N_REQ-1:0] req_code,
    input  logic [N_REQ-1:0]        req_fast,
    output logic [N_REQ-1:0]        req_done,
    output logic [N_REQ-1:0]        pending,
    output logic [CODE_W-1:0]       fl_mode,
    output logic                    fl_fast,
    input  logic                    fl_busy,
    output logic                    active,
    output logic [ID_W-1:0]         active_id,
    output logic                    err_nostart
);

    localparam int CW = $clog2(max2(START_TMO, GAP_CYC) + 1);
    // Counters load N-1 and run down to 0, so a phase lasts exactly N cycles.
    localparam logic [CW-1:0]   TMO_LD  = CW'((START_TMO > 0) ? START_TMO - 1 : 0);
    localparam logic [CW-1:0]   GAP_LD  = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [ID_W-1:0] PTR_RST = ID_W'(N_REQ - 1);

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [ID_W-1:0]     ptr;
    logic [CODE_W-1:0]   code_q [N_REQ];
    logic [N_REQ-1:0]    fast_q;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    gnt_q;
    logic [N_REQ-1:0]    post;
    logic [ID_W-1:0]     gidx;
    logic [CODE_W-1:0]   sel_code;
    logic                sel_fast;
    logic                grant;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req (pending),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gidx)
    );

    // A zero code is not a request at all.
    always_comb begin
        post = '0;
        for (int i = 0; i < N_REQ; i++)
            post[i] = req_valid[i] && (req_code[i*CODE_W +: CODE_W] != '0);
    end

    always_comb begin
        sel_code = '0;
        sel_fast = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_code = code_q[i];
                sel_fast = fast_q[i];
            end
        end
    end

    assign grant = (state == S_IDLE) && (|pending) && !fl_busy;

    // Per-requester slot. A post in the grant cycle wins over the clear, so
    // the issue carries the old code while the new one stays pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            fast_q  <= '0;
            for (int i = 0; i < N_REQ; i++)
                code_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (post[i]) begin
                    pending[i] <= 1'b1;
                    code_q[i]  <= req_code[i*CODE_W +: CODE_W];
                    fast_q[i]  <= req_fast[i];
                end else if (grant && gnt[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            ptr         <= PTR_RST;
            gnt_q       <= '0;
            fl_mode     <= '0;
            fl_fast     <= 1'b0;
            req_done    <= '0;
            active      <= 1'b0;
            active_id   <= '0;
            err_nostart <= 1'b0;
        end else begin
            fl_mode  <= '0;
            fl_fast  <= 1'b0;
            req_done <= '0;
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        state     <= S_ISSUE;
                        fl_mode   <= sel_code;
                        fl_fast   <= sel_fast;
                        active    <= 1'b1;
                        active_id <= gidx;
                        ptr       <= gidx;
                        gnt_q     <= gnt;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT_BUSY;
                    cnt   <= TMO_LD;
                end
                S_WAIT_BUSY: begin
                    if (fl_busy) begin
                        state <= S_WAIT_DONE;
                    end else if (cnt == '0) begin
                        err_nostart <= 1'b1;
                        req_done    <= gnt_q;
                        active      <= 1'b0;
                        cnt         <= GAP_LD;
                        state       <= S_GAP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!fl_busy) begin
                        req_done <= gnt_q;
                        active   <= 1'b0;
                        cnt      <= GAP_LD;
                        state    <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (cnt == '0)
                        state <= S_IDLE;
                    else
                        cnt <= cnt - 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_code_sched.sv
// tb_led_code_sched: vector, directed and randomized checks of led_code_sched
module tb_led_code_sched;
    import led_code_sched_pkg::*;

    localparam int N   = 4;
    localparam int TMO = 8;
    localparam int GAP = 16;
    localparam int CB  = 4 * N;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [CB-1:0]   req_code  = '0;
    logic [N-1:0]    req_fast  = '0;
    logic [N-1:0]    req_done;
    logic [N-1:0]    pending;
    logic [3:0]      fl_mode;
    logic            fl_fast;
    logic            fl_busy;
    logic            active;
    logic [ID_W-1:0] active_id;
    logic            err_nostart;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   blen = 5;
    int   bcnt = 0;
    logic fl_dead = 1'b0;
    logic busy_hold = 1'b0;
    logic fl_clr = 1'b0;

    led_code_sched #(.N_REQ(N), .START_TMO(TMO), .GAP_CYC(GAP)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_code(req_code),
        .req_fast(req_fast), .req_done(req_done), .pending(pending),
        .fl_mode(fl_mode), .fl_fast(fl_fast), .fl_busy(fl_busy),
        .active(active), .active_id(active_id), .err_nostart(err_nostart)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Flasher model: goes busy the cycle after it sees a code, for blen cycles.
    always @(posedge clk) begin
        if (fl_clr) bcnt <= 0;
        else if (fl_mode != 0) bcnt <= fl_dead ? 0 : blen;
        else if (bcnt != 0) bcnt <= bcnt - 1;
    end
    assign fl_busy = (bcnt != 0) || busy_hold;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] oh(input int i);
        return N'(1) << i;
    endfunction

    task automatic post(input int id, input logic [3:0] code, input logic f);
        req_valid = req_valid | oh(id);
        req_fast  = f ? (req_fast | oh(id)) : (req_fast & ~oh(id));
        req_code  = (req_code & ~(CB'(15) << (4 * id))) | (CB'(code) << (4 * id));
    endtask

    task automatic rst_dut();
        rst = 1'b1;
        req_valid = '0;
        busy_hold = 1'b0;
        fl_clr = 1'b1;
        next();
        next();
        rst = 1'b0;
        fl_clr = 1'b0;
    endtask

    // Reference model for the random phase: slots, last-served index, in-flight id.
    logic [N-1:0]  mp;
    logic [3:0]    mc [N];
    logic          mf [N];
    int            last, aid, last_done, nissue, ndone;
    logic          act, pbusy;
    logic [N-1:0]  pv, pf;
    logic [CB-1:0] pc;

    function automatic int rr(input logic [N-1:0] p, input int lst);
        for (int k = 1; k <= N; k++)
            if (p[(lst + k) % N]) return (lst + k) % N;
        return -1;
    endfunction

    task automatic model_step();
        int g;
        if (fl_mode != 0) begin
            g = rr(mp, last);
            chk("rand_grant_valid", (g >= 0), 1);
            if (g >= 0) begin
                chk("rand_grant_id", active_id, g);
                chk("rand_mode", fl_mode, mc[g]);
                chk("rand_fast", fl_fast, mf[g]);
                mp[g] = 1'b0;
                last = g;
            end
            chk("rand_overlap", act, 0);
            chk("rand_gap", (ndone == 0 || cyc - last_done >= GAP + 1), 1);
            act = 1'b1;
            aid = g;
            nissue++;
        end else if (!act && mp != 0 && !pbusy && (ndone == 0 || cyc - last_done >= GAP + 1)) begin
            chk("rand_issue_due", 0, 1);
        end
        if (req_done != 0) begin
            chk("rand_done", req_done, act ? oh(aid) : '0);
            act = 1'b0;
            last_done = cyc;
            ndone++;
        end
        for (int i = 0; i < N; i++) begin
            if (pv[i] && pc[4*i +: 4] != 0) begin
                mp[i] = 1'b1;
                mc[i] = pc[4*i +: 4];
                mf[i] = pf[i];
            end
        end
        chk("rand_pending", pending, mp);
        chk("rand_active", active, act);
        if (act) chk("rand_active_id", active_id, aid);
    endtask

    typedef struct {
        int         id;
        logic [3:0] code;
        logic       fast;
        int         blen;
        int         exp_mode;
        int         exp_fast;
        int         exp_done;
    } vec_t;

    vec_t tv [5];

    initial begin
        int done_at, extra, ni, nd, c2, m2, bad, got;
        logic [N-1:0] done_val;
        int iss_c [4];
        int iss_id [4];
        int iss_m [4];
        int don_c [4];

        // Issue lands in cycle 2; flasher busy from cycle 3 for blen cycles;
        // done one cycle after busy falls, i.e. cycle blen+4.
        tv[0] = '{0, 4'd3,  1'b0, 20, 3,  0, 24};
        tv[1] = '{2, 4'd9,  1'b1, 5,  9,  1, 9};
        tv[2] = '{1, 4'd0,  1'b1, 5,  0,  0, -1};
        tv[3] = '{3, 4'd15, 1'b0, 1,  15, 0, 5};
        tv[4] = '{0, 4'd1,  1'b1, 3,  1,  1, 7};

        for (int v = 0; v < 5; v++) begin
            rst_dut();
            if (v == 0) begin
                chk("rst_pending", pending, 0);
                chk("rst_mode", fl_mode, 0);
                chk("rst_active", active, 0);
                chk("rst_active_id", active_id, 0);
                chk("rst_err", err_nostart, 0);
                chk("rst_done", req_done, 0);
            end
            blen = tv[v].blen;
            fl_dead = 1'b0;
            post(tv[v].id, tv[v].code, tv[v].fast);
            done_at = -1;
            done_val = '0;
            extra = 0;
            for (int c = 1; c <= 30; c++) begin
                next();
                req_valid = '0;
                if (c == 1) chk("vec_pending", pending, tv[v].exp_mode != 0 ? oh(tv[v].id) : '0);
                if (c == 2) begin
                    chk("vec_mode", fl_mode, tv[v].exp_mode);
                    chk("vec_fast", fl_fast, tv[v].exp_fast);
                    chk("vec_active", active, tv[v].exp_mode != 0);
                end else if (fl_mode != 0) begin
                    extra++;
                end
                if (req_done != 0 && done_at < 0) begin
                    done_at = c;
                    done_val = req_done;
                end
            end
            chk("vec_extra_issue", extra, 0);
            chk("vec_done_at", done_at, tv[v].exp_done);
            chk("vec_done_id", done_val, tv[v].exp_done >= 0 ? oh(tv[v].id) : '0);
        end

        // All four post together: served 0,1,2,3 with a full gap between.
        rst_dut();
        blen = 5;
        for (int i = 0; i < 4; i++) post(i, 4'(i + 1), 1'b0);
        ni = 0;
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            iss_c[i] = 0; iss_id[i] = -1; iss_m[i] = 0; don_c[i] = 0;
        end
        for (int c = 1; c <= 400; c++) begin
            next();
            req_valid = '0;
            if (fl_mode != 0) begin
                if (ni < 4) begin
                    iss_c[ni] = c; iss_id[ni] = int'(active_id); iss_m[ni] = int'(fl_mode);
                end
                ni++;
            end
            if (req_done != 0) begin
                if (nd < 4) don_c[nd] = c;
                nd++;
            end
        end
        chk("all4_issues", ni, 4);
        chk("all4_dones", nd, 4);
        chk("all4_first_at", iss_c[0], 2);
        for (int k = 0; k < 4; k++) begin
            chk("all4_order", iss_id[k], k);
            chk("all4_code", iss_m[k], k + 1);
        end
        for (int k = 1; k < 4; k++)
            chk("all4_gap", (iss_c[k] - don_c[k-1] - 1 >= GAP), 1);

        // Flasher never goes busy: timeout, error, done, then next requester.
        rst_dut();
        fl_dead = 1'b1;
        post(0, 4'd6, 1'b0);
        post(1, 4'd2, 1'b1);
        c2 = -1;
        m2 = 0;
        for (int c = 1; c <= 60; c++) begin
            next();
            req_valid = '0;
            if (c == 2) chk("tmo_first_mode", fl_mode, 6);
            if (c == 10) chk("tmo_err_early", err_nostart, 0);
            if (c == 11) begin
                chk("tmo_err", err_nostart, 1);
                chk("tmo_done", req_done, oh(0));
            end
            if (c > 2 && fl_mode != 0 && c2 < 0) begin
                c2 = c;
                m2 = int'(fl_mode);
                chk("tmo_next_id", active_id, 1);
            end
        end
        chk("tmo_next_at", c2, 11 + GAP + 1);
        chk("tmo_next_mode", m2, 2);
        chk("tmo_err_sticky", err_nostart, 1);
        fl_dead = 1'b0;

        // Repost while active: old code completes, new one follows after gap.
        rst_dut();
        blen = 10;
        post(1, 4'd2, 1'b0);
        c2 = -1;
        m2 = 0;
        for (int c = 1; c <= 60; c++) begin
            next();
            req_valid = '0;
            if (c == 2) chk("repost_first", fl_mode, 2);
            if (c == 5) post(1, 4'd5, 1'b0);
            if (c == 6) begin
                chk("repost_pending", pending, oh(1));
                chk("repost_active", active, 1);
            end
            if (c == 14) chk("repost_done", req_done, oh(1));
            if (c > 2 && fl_mode != 0 && c2 < 0) begin
                c2 = c;
                m2 = int'(fl_mode);
            end
        end
        chk("repost_next_at", c2, 14 + GAP + 1);
        chk("repost_next_mode", m2, 5);

        // Post in the grant cycle: issue carries old code, new stays pending.
        rst_dut();
        blen = 3;
        post(0, 4'd1, 1'b0);
        next();
        req_valid = '0;
        post(0, 4'd9, 1'b1);
        next();
        req_valid = '0;
        chk("same_cyc_mode", fl_mode, 1);
        chk("same_cyc_fast", fl_fast, 0);
        chk("same_cyc_pending", pending, oh(0));
        m2 = 0;
        for (int c = 0; c < 60; c++) begin
            next();
            if (fl_mode != 0 && m2 == 0) begin
                m2 = int'(fl_mode);
                chk("same_cyc_next_fast", fl_fast, 1);
            end
        end
        chk("same_cyc_next_mode", m2, 9);

        // Reset during WAIT_DONE with the flasher still busy.
        rst_dut();
        blen = 40;
        post(0, 4'd3, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            next();
            req_valid = '0;
            if (c == 6) post(1, 4'd4, 1'b0);
        end
        chk("rstmid_active_before", active, 1);
        rst = 1'b1;
        busy_hold = 1'b1;
        fl_clr = 1'b1;
        next();
        rst = 1'b0;
        fl_clr = 1'b0;
        chk("rstmid_pending", pending, 0);
        chk("rstmid_active", active, 0);
        bad = (req_done != 0 || fl_mode != 0) ? 1 : 0;
        post(2, 4'd7, 1'b0);
        for (int k = 1; k < 10; k++) begin
            next();
            req_valid = '0;
            if (req_done != 0 || fl_mode != 0) bad++;
        end
        chk("rstmid_quiet", bad, 0);
        chk("rstmid_new_pending", pending, oh(2));
        busy_hold = 1'b0;
        got = 0;
        for (int k = 0; k < 10; k++) begin
            next();
            if (fl_mode != 0 && got == 0) begin
                got = int'(fl_mode);
                chk("rstmid_issue_id", active_id, 2);
            end
        end
        chk("rstmid_issue_mode", got, 7);

        // Random traffic against the reference model.
        rst_dut();
        mp = '0;
        for (int i = 0; i < N; i++) begin mc[i] = '0; mf[i] = 1'b0; end
        last = N - 1;
        aid = 0;
        act = 1'b0;
        last_done = 0;
        nissue = 0;
        ndone = 0;
        for (int t = 0; t < 3000; t++) begin
            req_valid = '0;
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 19) == 0) post(i, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            blen = $urandom_range(1, 12);
            fl_dead = ($urandom_range(0, 9) == 0);
            pv = req_valid; pc = req_code; pf = req_fast; pbusy = fl_busy;
            next();
            model_step();
        end
        req_valid = '0;
        fl_dead = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            pv = '0; pc = req_code; pf = req_fast; pbusy = fl_busy;
            next();
            model_step();
            if (mp == 0 && !act) break;
        end
        chk("rand_drain", {pending, active}, 0);
        chk("rand_issue_done_match", nissue, ndone);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_code_sched.md
LED_CODE_SCHED -- requirements
Module: led_code_sched

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one led_flash instance (2..8).
REQ-002 Parameter START_TMO, default 8, cycles to wait for fl_busy to rise after issue.
REQ-003 Parameter GAP_CYC, default 1000, idle cycles between two consecutive codes.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  N_REQ  one-cycle pulse per requester posting a code.
REQ-007 req_code  in  4*N_REQ  blink count per requester (nibble i belongs to requester i).
REQ-008 req_fast  in  N_REQ  fast-blink flag per requester.
REQ-009 req_done  out  N_REQ  one-cycle pulse when requester i's code finished or was dropped.
REQ-010 pending  out  N_REQ  requester i holds an unserved code.
REQ-011 fl_mode  out  4  mode to flasher; nonzero exactly one cycle per issue, else 0.
REQ-012 fl_fast  out  1  fast flag to flasher, valid with fl_mode.
REQ-013 fl_busy  in  1  flasher busy.
REQ-014 active  out  1  a code is in flight; active_id  out  3  its requester index.
REQ-015 err_nostart  out  1  sticky: flasher failed to go busy within START_TMO.

Function
REQ-016 req_valid[i] with code!=0 SHALL set pending[i] and store code/fast next cycle; code 0 SHALL be ignored.
REQ-017 req_valid[i] while pending[i] and not active SHALL overwrite stored code; while i is active SHALL queue it as new pending (per-requester slot, latest wins).
REQ-018 States IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP.
REQ-019 IDLE: when any pending and fl_busy==0, round-robin grant starting after last served index; go ISSUE.
REQ-020 ISSUE (one cycle): fl_mode=stored code, fl_fast=stored fast, clear pending[grant], active=1; go WAIT_BUSY.
REQ-021 WAIT_BUSY: fl_busy==1 -> WAIT_DONE; START_TMO cycles without it -> set err_nostart, pulse req_done[grant], go GAP.
REQ-022 WAIT_DONE: fl_busy==0 -> pulse req_done[grant], active=0, load GAP_CYC counter, go GAP.
REQ-023 GAP: decrement to 0, then IDLE; new requests accepted during GAP.
REQ-024 Latency single pending request from IDLE: req_valid at cycle 0 -> fl_mode nonzero at cycle 2.
REQ-025 Round-robin pointer SHALL update only on grant; with all N_REQ pending, service order SHALL be fair (each served once per N_REQ grants).
REQ-026 Simultaneous req_valid[i] and grant to i in same cycle: grant uses old code, new code becomes pending.
REQ-027 Counters SHALL saturate at 0; widths SHALL cover max(START_TMO, GAP_CYC).

Reset
REQ-028 rst: state IDLE, pending=0, stored codes 0, fl_mode=0, fl_fast=0, req_done=0, active=0, active_id=0, err_nostart=0, RR pointer to N_REQ-1 (requester 0 first).
REQ-029 Reset mid-operation SHALL drop the in-flight code without req_done; IDLE SHALL not issue while fl_busy is still 1.

Structure
REQ-030 Shared package SHALL hold state enum, code width (4) and max N_REQ constant.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (request vector, pointer in; one-hot grant, index out, purely combinational).

Verification
REQ-032 Single request code 3, fast 0, flasher model busy 20 cycles -> fl_mode=3 for one cycle at cycle 2, req_done[0] pulse 1 cycle after busy falls.
REQ-033 All 4 requesters pulse same cycle (codes 1,2,3,4) -> issue order 0,1,2,3, each separated by >= GAP_CYC idle cycles.
REQ-034 Flasher model never asserts busy -> after START_TMO=8 cycles err_nostart=1, req_done pulsed, next pending served.
REQ-035 Requester 1 reposts code 5 while its code 2 is active -> code 2 completes, then code 5 issued after gap.
REQ-036 rst asserted in WAIT_DONE with fl_busy held 1 for 10 more cycles -> no req_done, pending=0, no fl_mode pulse until fl_busy=0.
REQ-037 req_valid with code 0 -> pending unchanged, no issue.
